// File: rtl/user_input_pkg.sv
// Shared encodings for the ATM keyboard-entry front end: entry styles, status codes,
// currency codes and the control keystrokes it recognises.
package user_input_pkg;

  typedef enum logic [3:0] {
    StyleAcct     = 4'b0001,
    StylePswd     = 4'b0010,
    StyleDest     = 4'b0011,
    StyleCurrency = 4'b0100,
    StyleMenu     = 4'b1000
  } style_e;

  typedef enum logic [3:0] {
    StatIdle     = 4'h0,
    StatBusy     = 4'h1,
    StatDone     = 4'h2,
    StatBadChar  = 4'h3,
    StatShort    = 4'h4,
    StatBadStyle = 4'h5,
    StatOverflow = 4'h6
  } status_e;

  localparam logic [2:0] CurNone = 3'd0;
  localparam logic [2:0] CurBtc  = 3'd1;
  localparam logic [2:0] CurEth  = 3'd2;
  localparam logic [2:0] CurLtc  = 3'd3;
  localparam logic [2:0] CurCash = 3'd4;

  localparam logic [7:0] AsciiEnter = 8'h0D;
  localparam logic [7:0] AsciiBksp  = 8'h08;
  localparam logic [7:0] AsciiEsc   = 8'h1B;

  localparam logic [2:0] DigitsPerEntry = 3'd4;

  function automatic logic is_digit_style(input logic [3:0] style);
    return (style == StyleAcct) || (style == StylePswd) || (style == StyleDest);
  endfunction

endpackage

// File: rtl/user_input_ascii_decoder.sv
// Purely combinational keystroke classifier: digit nibble, currency letter code and
// menu choice index, each with its own hit flag.
module ascii_decoder
  import user_input_pkg::*;
(
  input  logic [7:0] ascii_code,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_currency,
  output logic [2:0] currency,
  output logic       is_menu,
  output logic [1:0] choice
);

  logic [7:0] menu_offset;

  always_comb begin
    is_digit = (ascii_code >= 8'h30) && (ascii_code <= 8'h39);
    digit    = is_digit ? ascii_code[3:0] : 4'h0;
  end

  always_comb begin
    is_currency = 1'b1;
    currency    = CurNone;
    case (ascii_code)
      8'h62:   currency = CurBtc;   // 'b'
      8'h65:   currency = CurEth;   // 'e'
      8'h6C:   currency = CurLtc;   // 'l'
      8'h63:   currency = CurCash;  // 'c'
      default: is_currency = 1'b0;
    endcase
  end

  // '1'..'4' map to choices 0..3
  always_comb begin
    menu_offset = ascii_code - 8'h31;
    is_menu     = (ascii_code >= 8'h31) && (ascii_code <= 8'h34);
    choice      = is_menu ? menu_offset[1:0] : 2'd0;
  end

endmodule

// File: rtl/user_input.sv
// Keyboard-entry front end: assembles BCD digit entries and single-letter selections
// one keystroke per ready strobe, and holds committed values as registered outputs.
module user_input
  import user_input_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ascii_code,
  input  logic        ready,
  input  logic [3:0]  input_style_out,
  input  logic [15:0] current_state,
  output logic [3:0]  status_code_out,
  output logic [15:0] acct,
  output logic [15:0] pswd,
  output logic [15:0] destinationAcc,
  output logic [1:0]  usr_input_out,
  output logic [2:0]  currency_type_out,
  output logic [2:0]  currency_type_2_out
);

  logic       dec_is_digit, dec_is_currency, dec_is_menu;
  logic [3:0] dec_digit;
  logic [2:0] dec_currency;
  logic [1:0] dec_choice;

  ascii_decoder u_ascii_decoder (
    .ascii_code  (ascii_code),
    .is_digit    (dec_is_digit),
    .digit       (dec_digit),
    .is_currency (dec_is_currency),
    .currency    (dec_currency),
    .is_menu     (dec_is_menu),
    .choice      (dec_choice)
  );

  logic [3:0]  style_q, style_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  status_e     status_q, status_d;
  logic [15:0] acct_q, acct_d;
  logic [15:0] pswd_q, pswd_d;
  logic [15:0] dest_q, dest_d;
  logic [1:0]  usr_q, usr_d;
  logic [2:0]  cur_q, cur_d;
  logic [2:0]  cur2_q, cur2_d;

  logic       is_enter, is_bksp, is_esc;
  logic       sel_hit;
  logic [2:0] sel_code;

  always_comb begin
    is_enter = (ascii_code == AsciiEnter);
    is_bksp  = (ascii_code == AsciiBksp);
    is_esc   = (ascii_code == AsciiEsc);
    // Currency and menu share the single pending register
    if (input_style_out == StyleCurrency) begin
      sel_hit  = dec_is_currency;
      sel_code = dec_currency;
    end else begin
      sel_hit  = dec_is_menu;
      sel_code = {1'b0, dec_choice};
    end
  end

  always_comb begin
    style_d    = input_style_out;
    entry_d    = entry_q;
    count_d    = count_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    status_d   = status_q;
    acct_d     = acct_q;
    pswd_d     = pswd_q;
    dest_d     = dest_q;
    usr_d      = usr_q;
    cur_d      = cur_q;
    cur2_d     = cur2_q;

    if (current_state[0]) begin
      // Welcome/logout wipes everything, including the style history
      style_d    = 4'h0;
      entry_d    = 16'h0;
      count_d    = 3'd0;
      pend_d     = 3'd0;
      pend_vld_d = 1'b0;
      status_d   = StatIdle;
      acct_d     = 16'h0;
      pswd_d     = 16'h0;
      dest_d     = 16'h0;
      usr_d      = 2'd0;
      cur_d      = 3'd0;
      cur2_d     = 3'd0;
    end else if (input_style_out != style_q) begin
      // New context: drop partial work and any key arriving this cycle
      entry_d    = 16'h0;
      count_d    = 3'd0;
      pend_d     = 3'd0;
      pend_vld_d = 1'b0;
      status_d   = StatIdle;
    end else if (ready) begin
      if (is_digit_style(input_style_out)) begin
        if (dec_is_digit) begin
          if (count_q == DigitsPerEntry) begin
            status_d = StatOverflow;
          end else begin
            entry_d  = {entry_q[11:0], dec_digit};
            count_d  = count_q + 3'd1;
            status_d = StatBusy;
          end
        end else if (is_bksp) begin
          entry_d  = entry_q >> 4;
          count_d  = (count_q == 3'd0) ? 3'd0 : count_q - 3'd1;
          status_d = StatBusy;
        end else if (is_esc) begin
          entry_d  = 16'h0;
          count_d  = 3'd0;
          status_d = StatIdle;
        end else if (is_enter) begin
          if (count_q == DigitsPerEntry) begin
            case (input_style_out)
              StyleAcct: acct_d = entry_q;
              StylePswd: pswd_d = entry_q;
              default:   dest_d = entry_q;
            endcase
            status_d = StatDone;
          end else begin
            status_d = StatShort;
          end
          entry_d = 16'h0;
          count_d = 3'd0;
        end else begin
          status_d = StatBadChar;
        end
      end else if ((input_style_out == StyleCurrency) || (input_style_out == StyleMenu)) begin
        if (sel_hit) begin
          pend_d     = sel_code;
          pend_vld_d = 1'b1;
          status_d   = StatBusy;
        end else if (is_bksp || is_esc) begin
          pend_d     = 3'd0;
          pend_vld_d = 1'b0;
          status_d   = StatIdle;
        end else if (is_enter) begin
          if (pend_vld_q) begin
            if (input_style_out == StyleMenu) begin
              usr_d = pend_q[1:0];
            end else if (current_state[4]) begin
              cur2_d = pend_q;
            end else begin
              cur_d = pend_q;
            end
            status_d   = StatDone;
            pend_d     = 3'd0;
            pend_vld_d = 1'b0;
          end else begin
            status_d = StatShort;
          end
        end else begin
          status_d = StatBadChar;
        end
      end else begin
        status_d = StatBadStyle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      style_q    <= 4'h0;
      entry_q    <= 16'h0;
      count_q    <= 3'd0;
      pend_q     <= 3'd0;
      pend_vld_q <= 1'b0;
      status_q   <= StatIdle;
      acct_q     <= 16'h0;
      pswd_q     <= 16'h0;
      dest_q     <= 16'h0;
      usr_q      <= 2'd0;
      cur_q      <= 3'd0;
      cur2_q     <= 3'd0;
    end else begin
      style_q    <= style_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      status_q   <= status_d;
      acct_q     <= acct_d;
      pswd_q     <= pswd_d;
      dest_q     <= dest_d;
      usr_q      <= usr_d;
      cur_q      <= cur_d;
      cur2_q     <= cur2_d;
    end
  end

  assign status_code_out     = status_q;
  assign acct                = acct_q;
  assign pswd                = pswd_q;
  assign destinationAcc      = dest_q;
  assign usr_input_out       = usr_q;
  assign currency_type_out   = cur_q;
  assign currency_type_2_out = cur2_q;

endmodule

// File: tb/tb_user_input.sv
// Directed bench for user_input: expectations are queued as keys are driven and
// popped against the registered outputs one time unit after each clock edge.
module tb_user_input;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ascii_code;
  logic        ready;
  logic [3:0]  input_style_out;
  logic [15:0] current_state;
  logic [3:0]  status_code_out;
  logic [15:0] acct, pswd, destinationAcc;
  logic [1:0]  usr_input_out;
  logic [2:0]  currency_type_out, currency_type_2_out;

  user_input dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ascii_code          (ascii_code),
    .ready               (ready),
    .input_style_out     (input_style_out),
    .current_state       (current_state),
    .status_code_out     (status_code_out),
    .acct                (acct),
    .pswd                (pswd),
    .destinationAcc      (destinationAcc),
    .usr_input_out       (usr_input_out),
    .currency_type_out   (currency_type_out),
    .currency_type_2_out (currency_type_2_out)
  );

  always #5 clk = ~clk;

  typedef enum int {SelStatus, SelAcct, SelPswd, SelDest, SelUsr, SelCur, SelCur2} sel_e;

  typedef struct {
    sel_e        sel;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [7:0] KEnter = 8'h0D;
  localparam logic [7:0] KBksp  = 8'h08;
  localparam logic [7:0] KEsc   = 8'h1B;

  function automatic logic [15:0] observe(input sel_e sel);
    case (sel)
      SelStatus: return {12'h0, status_code_out};
      SelAcct:   return acct;
      SelPswd:   return pswd;
      SelDest:   return destinationAcc;
      SelUsr:    return {14'h0, usr_input_out};
      SelCur:    return {13'h0, currency_type_out};
      default:   return {13'h0, currency_type_2_out};
    endcase
  endfunction

  task automatic expect_val(input sel_e sel, input logic [15:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input string tag);
    expect_val(SelStatus, 16'h0, {tag, "_status"});
    expect_val(SelAcct,   16'h0, {tag, "_acct"});
    expect_val(SelPswd,   16'h0, {tag, "_pswd"});
    expect_val(SelDest,   16'h0, {tag, "_dest"});
    expect_val(SelUsr,    16'h0, {tag, "_usr"});
    expect_val(SelCur,    16'h0, {tag, "_cur"});
    expect_val(SelCur2,   16'h0, {tag, "_cur2"});
  endtask

  task automatic check_all();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.val) passed++;
      else $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic key(input logic [7:0] k);
    @(negedge clk);
    ascii_code = k;
    ready      = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic keys4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d);
    key(a);
    key(b);
    key(c);
    key(d);
  endtask

  task automatic set_ctx(input logic [3:0] style, input logic [15:0] cs);
    @(negedge clk);
    input_style_out = style;
    current_state   = cs;
    ready           = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    ready           = 1'b0;
    ascii_code      = 8'h00;
    input_style_out = 4'h0;
    current_state   = 16'h0002;
    #12;
    expect_all_zero("reset");
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // ACCT entry
    set_ctx(4'h1, 16'h0002);
    expect_val(SelStatus, 16'h0, "acct_ctx_idle");
    check_all();
    keys4("1", "2", "7", "8");
    expect_val(SelStatus, 16'h1, "acct_busy");
    check_all();
    key(KEnter);
    expect_val(SelAcct, 16'h1278, "acct_commit");
    expect_val(SelStatus, 16'h2, "acct_done");
    expect_val(SelPswd, 16'h0, "acct_pswd_kept");
    check_all();

    // Currency to primary, then to exchange target
    set_ctx(4'h4, 16'h0008);
    key("c");
    key(KEnter);
    expect_val(SelCur, 16'd4, "cur_cash");
    expect_val(SelStatus, 16'h2, "cur_done");
    check_all();
    set_ctx(4'h4, 16'h0010);
    key("e");
    key(KEnter);
    expect_val(SelCur2, 16'd2, "cur2_eth");
    expect_val(SelCur, 16'd4, "cur_kept");
    expect_val(SelStatus, 16'h2, "cur2_done");
    check_all();
    key(KEnter);
    expect_val(SelStatus, 16'h4, "cur_enter_empty_short");
    expect_val(SelCur2, 16'd2, "cur2_kept_after_short");
    check_all();

    // PSWD: short entry, overflow, then full commit
    set_ctx(4'h2, 16'h0020);
    key("4");
    key("2");
    key(KEnter);
    expect_val(SelStatus, 16'h4, "pswd_short");
    expect_val(SelPswd, 16'h0, "pswd_unchanged");
    check_all();
    keys4("1", "2", "3", "4");
    expect_val(SelStatus, 16'h1, "pswd_busy4");
    check_all();
    key("5");
    expect_val(SelStatus, 16'h6, "pswd_overflow");
    check_all();
    key(KEnter);
    expect_val(SelPswd, 16'h1234, "pswd_commit");
    expect_val(SelStatus, 16'h2, "pswd_done");
    check_all();

    // MENU
    set_ctx(4'h8, 16'h0040);
    key("x");
    expect_val(SelStatus, 16'h3, "menu_badchar");
    check_all();
    key(KEnter);
    expect_val(SelStatus, 16'h4, "menu_empty_short");
    check_all();
    key("3");
    key(KEnter);
    expect_val(SelUsr, 16'd2, "menu_commit");
    expect_val(SelStatus, 16'h2, "menu_done");
    check_all();
    key("2");
    key(KBksp);
    key(KEnter);
    expect_val(SelStatus, 16'h4, "menu_bksp_short");
    expect_val(SelUsr, 16'd2, "menu_kept");
    check_all();

    // Unknown style
    set_ctx(4'h6, 16'h0040);
    key("1");
    expect_val(SelStatus, 16'h5, "bad_style");
    check_all();

    // DEST with escape, then full commit
    set_ctx(4'h3, 16'h0080);
    key("1");
    key("2");
    key(KEsc);
    expect_val(SelStatus, 16'h0, "dest_esc_idle");
    check_all();
    keys4("4", "3", "2", "1");
    key(KEnter);
    expect_val(SelDest, 16'h4321, "dest_commit");
    check_all();

    // Partial DEST, then style change with a key in the same cycle
    key("9");
    key("8");
    @(negedge clk);
    input_style_out = 4'h1;
    ascii_code      = "7";
    ready           = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    expect_val(SelStatus, 16'h0, "style_change_idle");
    expect_val(SelDest, 16'h4321, "style_change_dest_kept");
    check_all();
    key("5");
    key("6");
    key(KBksp);
    key("7");
    key("8");
    key("9");
    key(KEnter);
    expect_val(SelAcct, 16'h5789, "acct_after_change_bksp");
    expect_val(SelStatus, 16'h2, "acct_after_change_done");
    check_all();

    // Logout clears everything, key in the same cycle ignored
    @(negedge clk);
    current_state = 16'h0001;
    ascii_code    = KEnter;
    ready         = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    expect_all_zero("logout");
    check_all();

    // Async reset mid-entry
    set_ctx(4'h1, 16'h0002);
    keys4("2", "2", "2", "2");
    key(KEnter);
    expect_val(SelAcct, 16'h2222, "acct_before_rst");
    check_all();
    key("3");
    key("4");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all_zero("async_rst");
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    set_ctx(4'h1, 16'h0002);
    key(KEnter);
    expect_val(SelStatus, 16'h4, "after_rst_short");
    expect_val(SelAcct, 16'h0, "after_rst_acct");
    check_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
